// File: rtl/seven_seg_scanner_if.sv
// Bundle of display-value inputs and segment/anode outputs for the seven-segment scanner.
// The master side produces the value to show and the slave side drives the display pins.
interface seven_seg_scanner_if;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        lz_en;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame_tick;

    modport master (
        output data_in, dp_in, digit_en, lz_en,
        input  seg_out, dp_out, an, frame_tick
    );

    modport slave (
        input  data_in, dp_in, digit_en, lz_en,
        output seg_out, dp_out, an, frame_tick
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with inter-digit blanking,
// leading-zero suppression and frame-synchronous capture of the displayed value.
module seven_seg_scanner #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    seven_seg_scanner_if.slave bus
);
    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [15:0]   data_q, data_d;
    logic [3:0]    dp_q, dp_d;
    logic [3:0]    en_q, en_d;
    logic          lz_q, lz_d;
    logic          wrap_q, wrap_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dpo_q, dpo_d;
    logic          tick_q, tick_d;

    logic          slot_end_s;
    logic          blank_s;
    logic          lit_s;
    logic [15:0]   upper_s;

    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] f;
        case (nib)
            4'h0:    f = 7'h40;
            4'h1:    f = 7'h79;
            4'h2:    f = 7'h24;
            4'h3:    f = 7'h30;
            4'h4:    f = 7'h19;
            4'h5:    f = 7'h12;
            4'h6:    f = 7'h02;
            4'h7:    f = 7'h78;
            4'h8:    f = 7'h00;
            4'h9:    f = 7'h10;
            4'hA:    f = 7'h08;
            4'hB:    f = 7'h03;
            4'hC:    f = 7'h46;
            4'hD:    f = 7'h21;
            4'hE:    f = 7'h06;
            4'hF:    f = 7'h0E;
            default: f = 7'h7F;
        endcase
        return f;
    endfunction

    // With no blanking the comparison would be constant, so it is elided entirely.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign blank_s = 1'b0;
        end else begin : g_blank
            assign blank_s = (32'(cnt_q) < BLANK_CYCLES);
        end
    endgenerate

    // Next-state for prescaler, digit index, shadows and the registered display outputs.
    always_comb begin
        slot_end_s = (cnt_q == CNT_LAST);
        wrap_d     = slot_end_s && (dig_q == 2'd3);
        cnt_d      = slot_end_s ? {CW{1'b0}} : cnt_q + {{(CW-1){1'b0}}, 1'b1};
        dig_d      = slot_end_s ? dig_q + 2'd1 : dig_q;

        if (wrap_d) begin
            data_d = bus.data_in;
            dp_d   = bus.dp_in;
            en_d   = bus.digit_en;
            lz_d   = bus.lz_en;
        end else begin
            data_d = data_q;
            dp_d   = dp_q;
            en_d   = en_q;
            lz_d   = lz_q;
        end

        // Nibbles dig..3 shifted down; all-zero means this digit is a leading zero.
        upper_s = data_q >> {dig_q, 2'b00};
        lit_s   = en_q[dig_q] && !(lz_q && (dig_q != 2'd0) && (upper_s == 16'd0));

        if (blank_s || !lit_s) begin
            an_d  = 4'b1111;
            seg_d = 7'h7F;
            dpo_d = 1'b1;
        end else begin
            an_d  = ~(4'b0001 << dig_q);
            seg_d = hex_font(upper_s[3:0]);
            dpo_d = ~dp_q[dig_q];
        end
        tick_d = wrap_q;
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= {CW{1'b0}};
            dig_q  <= 2'd0;
            data_q <= 16'd0;
            dp_q   <= 4'd0;
            en_q   <= 4'd0;
            lz_q   <= 1'b0;
            wrap_q <= 1'b0;
            an_q   <= 4'b1111;
            seg_q  <= 7'h7F;
            dpo_q  <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dig_q  <= dig_d;
            data_q <= data_d;
            dp_q   <= dp_d;
            en_q   <= en_d;
            lz_q   <= lz_d;
            wrap_q <= wrap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dpo_q  <= dpo_d;
            tick_q <= tick_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg_out    = seg_q;
    assign bus.dp_out     = dpo_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: two instances (with and without blanking) checked every
// cycle against a frame/slot arithmetic model of the display.
module tb_seven_seg_scanner;
    localparam int S1 = 4;
    localparam int B1 = 1;
    localparam int S2 = 2;
    localparam int B2 = 0;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        lz;
    } shadow_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] data = 16'h0000;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  en = 4'h0;
    logic        lz = 1'b0;

    int edges = 0;
    int checks = 0;
    int errors = 0;
    shadow_t cap1[$];
    shadow_t cap2[$];

    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    seven_seg_scanner_if if1 ();
    seven_seg_scanner_if if2 ();

    assign if1.data_in  = data;
    assign if1.dp_in    = dp;
    assign if1.digit_en = en;
    assign if1.lz_en    = lz;
    assign if2.data_in  = data;
    assign if2.dp_in    = dp;
    assign if2.digit_en = en;
    assign if2.lz_en    = lz;

    seven_seg_scanner #(.SCAN_DIV(S1), .BLANK_CYCLES(B1)) dut1 (.clk(clk), .reset(rst_n), .bus(if1.slave));
    seven_seg_scanner #(.SCAN_DIV(S2), .BLANK_CYCLES(B2)) dut2 (.clk(clk), .reset(rst_n), .bus(if2.slave));

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s t=%0t edge=%0d observed %0h expected %0h", tag, $time, edges, obs, exp_v);
        end
    endtask

    // Expected pins after `edges` clock edges since reset release, given the frame's shadow.
    task automatic check_dut(input string nm, input int s, input int b, input shadow_t sh,
                             input logic [3:0] an_o, input logic [6:0] seg_o,
                             input logic dp_o, input logic tick_o);
        int p, cnt, dig;
        logic lit;
        logic [15:0] upper;
        logic [3:0] ea;
        logic [6:0] es;
        logic ed, et;
        p     = edges - 1;
        cnt   = p % s;
        dig   = (p / s) % 4;
        et    = (p % (4 * s) == 0) && (p > 0);
        upper = sh.d >> (4 * dig);
        lit   = sh.en[dig] && !(sh.lz && dig > 0 && upper == 16'd0);
        if (cnt < b || !lit) begin
            ea = 4'b1111;
            es = 7'h7F;
            ed = 1'b1;
        end else begin
            ea = ~(4'b0001 << dig);
            es = font[upper[3:0]];
            ed = ~sh.dp[dig];
        end
        cmp({nm, "_an"},   {12'd0, an_o},   {12'd0, ea});
        cmp({nm, "_seg"},  {9'd0, seg_o},   {9'd0, es});
        cmp({nm, "_dp"},   {15'd0, dp_o},   {15'd0, ed});
        cmp({nm, "_tick"}, {15'd0, tick_o}, {15'd0, et});
    endtask

    task automatic step();
        shadow_t s;
        @(posedge clk);
        edges++;
        s = {data, dp, en, lz};
        if (edges % (4 * S1) == 0) cap1.push_back(s);
        if (edges % (4 * S2) == 0) cap2.push_back(s);
        #1;
        check_dut("d1", S1, B1, cap1[(edges - 1) / (4 * S1)], if1.an, if1.seg_out, if1.dp_out, if1.frame_tick);
        check_dut("d2", S2, B2, cap2[(edges - 1) / (4 * S2)], if2.an, if2.seg_out, if2.dp_out, if2.frame_tick);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic check_reset_pins(input string tag);
        cmp({tag, "_an1"},   {12'd0, if1.an},          16'h000F);
        cmp({tag, "_seg1"},  {9'd0, if1.seg_out},      16'h007F);
        cmp({tag, "_dp1"},   {15'd0, if1.dp_out},      16'h0001);
        cmp({tag, "_tick1"}, {15'd0, if1.frame_tick},  16'h0000);
        cmp({tag, "_an2"},   {12'd0, if2.an},          16'h000F);
        cmp({tag, "_seg2"},  {9'd0, if2.seg_out},      16'h007F);
    endtask

    task automatic do_reset();
        shadow_t z;
        z = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_pins("rst_async");
        @(posedge clk);
        #1;
        check_reset_pins("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        cap1.delete();
        cap2.delete();
        cap1.push_back(z);
        cap2.push_back(z);
    endtask

    initial begin
        data = 16'h1A8F;
        dp   = 4'h0;
        en   = 4'hF;
        lz   = 1'b0;
        do_reset();
        run(40);

        data = 16'h1234;
        run(16);
        while (edges % (4 * S1) != 5) step();
        data = 16'h5678;
        run(40);

        lz   = 1'b1;
        data = 16'h0050;
        run(40);
        data = 16'h0000;
        run(40);

        lz   = 1'b0;
        en   = 4'b0101;
        dp   = 4'b0001;
        data = 16'hBEEF;
        run(40);

        repeat (40) begin
            data = 16'($urandom);
            dp   = 4'($urandom);
            en   = 4'($urandom);
            lz   = 1'($urandom);
            if ($urandom_range(0, 3) == 0) data = data & 16'h00FF;
            run(int'($urandom_range(1, 24)));
        end

        en   = 4'hF;
        data = 16'h9C3D;
        run(20);
        while (edges % (4 * S1) != 10) step();
        do_reset();
        run(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
